cle_sdrd_rx: RTL and testbench

- Downstream consumer of the CLE3 serial-read sequencer.
- Each qualified bus read slot (SSER low, BA13 low, BA12 high, BR_W high) presents one serial bit on SDRD. This block samples those bits and frames them into bytes.
- Completed bytes go into a small buffer for the host-side reader, with a valid/ready handshake.
- Framing, parity and overrun faults are reported as sticky status flags.

---
 rtl/cle_sdrd_rx.sv | 183 ++++++++++++++++++
 tb/tb_cle_sdrd_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cle_sdrd_rx.sv
// Frames serial SDRD bits from qualified read slots into bytes and buffers them for a valid/ready reader.
// Optional even-parity slot between data and stop bits is enabled by defining CLE_SDRD_PARITY_EN.
module cle_sdrd_rx #(
  parameter int DATA_BITS  = 8,
  parameter int SAMPLE_DLY = 1,
  parameter int TIMEOUT    = 255,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sser_n,
  input  logic                 ba13,
  input  logic                 ba12,
  input  logic                 br_w,
  input  logic                 sdrd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic                 err_clr,
  output logic                 ovr_err,
  output logic                 frm_err,
  output logic                 par_err,
  output logic                 busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0]  DEPTH_C  = (PW+1)'(FIFO_DEPTH);
  localparam logic [2:0]   LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [7:0]   TMO_C    = 8'(TIMEOUT);
  localparam logic [1:0]   DLY_M1   = (SAMPLE_DLY > 0) ? 2'(SAMPLE_DLY - 1) : 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Slot qualification and sample timing
  logic       slot_q, slot_prev_q, pend_q;
  logic [1:0] dly_q;
  logic       slot_evt, sample_en;

  assign slot_evt  = slot_q & ~slot_prev_q;
  assign sample_en = (SAMPLE_DLY == 0) ? slot_evt : (pend_q && (dly_q == 2'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q      <= 1'b0;
      slot_prev_q <= 1'b0;
      pend_q      <= 1'b0;
      dly_q       <= 2'd0;
    end else begin
      slot_q      <= ~sser_n & ~ba13 & ba12 & br_w;
      slot_prev_q <= slot_q;
      // Edges seen while a sample is still outstanding are dropped.
      if (SAMPLE_DLY != 0) begin
        if (pend_q) begin
          if (dly_q == 2'd0) pend_q <= 1'b0;
          else               dly_q  <= dly_q - 2'd1;
        end else if (slot_evt) begin
          pend_q <= 1'b1;
          dly_q  <= DLY_M1;
        end
      end
    end
  end

  // Framing state machine
  state_t                 state_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [2:0]             bitcnt_q;
  logic [7:0]             tmo_q;
  logic                   frm_err_q;
  logic                   push;

  assign push = (state_q == ST_STOP) && sample_en && sdrd;

`ifdef CLE_SDRD_PARITY_EN
  logic par_err_q;
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bitcnt_q  <= 3'd0;
      tmo_q     <= 8'd0;
      frm_err_q <= 1'b0;
`ifdef CLE_SDRD_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      if (err_clr) begin
        frm_err_q <= 1'b0;
`ifdef CLE_SDRD_PARITY_EN
        par_err_q <= 1'b0;
`endif
      end
      if (state_q == ST_IDLE) begin
        tmo_q <= 8'd0;
        if (sample_en && !sdrd) begin
          state_q  <= ST_DATA;
          bitcnt_q <= 3'd0;
        end
      end else if (sample_en) begin
        tmo_q <= 8'd0;
        case (state_q)
          ST_DATA: begin
            shift_q  <= {sdrd, shift_q[DATA_BITS-1:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == LAST_BIT) begin
`ifdef CLE_SDRD_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end
          end
`ifdef CLE_SDRD_PARITY_EN
          ST_PARITY: begin
            if (sdrd != ^shift_q) par_err_q <= 1'b1;
            state_q <= ST_STOP;
          end
`endif
          ST_STOP: begin
            // A 0 here is not taken as a new start bit.
            if (!sdrd) frm_err_q <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (tmo_q == TMO_C) begin
        frm_err_q <= 1'b1;
        state_q   <= ST_IDLE;
      end else begin
        tmo_q <= tmo_q + 8'd1;
      end
    end
  end

  assign frm_err = frm_err_q;
  assign busy    = (state_q != ST_IDLE);

  // Output byte buffer
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PW:0]          cnt_q;
  logic                 ovr_err_q, ovr_err_d;
  logic                 pop, full, push_ok;

  assign pop     = rx_valid & rx_ready;
  assign full    = (cnt_q == DEPTH_C);
  assign push_ok = push & (~full | pop);
  assign ovr_err_d = (ovr_err_q & ~err_clr) | (push & full & ~pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovr_err_q <= 1'b0;
    end else begin
      ovr_err_q <= ovr_err_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push_ok && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign rx_data  = mem_q[rd_ptr_q];
  assign rx_valid = (cnt_q != '0);
  assign ovr_err  = ovr_err_q;

endmodule

// File: tb/tb_cle_sdrd_rx.sv
// Directed bench for cle_sdrd_rx with hand-computed expectations; parity cases build with CLE_SDRD_PARITY_EN.
module tb_cle_sdrd_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sser_n, ba13, ba12, br_w, sdrd;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, err_clr;
  logic       ovr_err, frm_err, par_err, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cle_sdrd_rx dut (
    .clk      (clk),
    .rst      (rst),
    .sser_n   (sser_n),
    .ba13     (ba13),
    .ba12     (ba12),
    .br_w     (br_w),
    .sdrd     (sdrd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .err_clr  (err_clr),
    .ovr_err  (ovr_err),
    .frm_err  (frm_err),
    .par_err  (par_err),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int hold);
    sdrd   = b;
    sser_n = 1'b0;
    repeat (hold) tick();
    sser_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bit(1'b0, 3);
    for (int i = 0; i < 8; i++) send_bit(d[i], 3);
`ifdef CLE_SDRD_PARITY_EN
    send_bit(^d, 3);
`endif
    send_bit(1'b1, 3);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sser_n = 1'b1; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b1; sdrd = 1'b1;
    rx_ready = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    chk("rst_valid", rx_valid, 0);
    chk("rst_data",  rx_data,  8'h00);
    chk("rst_busy",  busy,     0);
    chk("rst_errs",  {ovr_err, frm_err, par_err}, 3'b000);
    rst = 1'b0;
    tick();

    // Basic frame 0x4A
    send_frame(8'h4A);
    chk("f4a_valid", rx_valid, 1);
    chk("f4a_data",  rx_data,  8'h4A);
    chk("f4a_busy",  busy,     0);
    chk("f4a_frm",   frm_err,  0);
    pop_one();
    chk("f4a_popped", rx_valid, 0);

    // Bad stop bit
    send_bit(1'b0, 3);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 3);
`ifdef CLE_SDRD_PARITY_EN
    send_bit(1'b0, 3);
`endif
    send_bit(1'b0, 3);
    chk("stop_frm",   frm_err,  1);
    chk("stop_valid", rx_valid, 0);
    chk("stop_busy",  busy,     0);
    clear_errs();
    chk("stop_clr",   frm_err,  0);

    // Overrun with a two-entry buffer
    send_frame(8'h11);
    send_frame(8'h22);
    chk("ovr_pre", ovr_err, 0);
    send_frame(8'h33);
    chk("ovr_set",   ovr_err, 1);
    chk("ovr_head0", rx_data, 8'h11);
    pop_one();
    chk("ovr_head1", rx_data, 8'h22);
    chk("ovr_valid1", rx_valid, 1);
    pop_one();
    chk("ovr_empty", rx_valid, 0);
    clear_errs();
    chk("ovr_clr", ovr_err, 0);

    // Mid-frame timeout
    send_bit(1'b0, 3);
    send_bit(1'b1, 3);
    send_bit(1'b0, 3);
    send_bit(1'b1, 3);
    chk("tmo_busy_mid", busy, 1);
    repeat (256) tick();
    chk("tmo_frm",  frm_err, 1);
    chk("tmo_busy", busy,    0);
    send_frame(8'hA5);
    chk("tmo_next_valid", rx_valid, 1);
    chk("tmo_next_data",  rx_data,  8'hA5);
    pop_one();
    clear_errs();

    // Non-read slot must not sample
    br_w = 1'b0;
    send_bit(1'b0, 3);
    br_w = 1'b1;
    chk("brw_busy", busy, 0);

    // Long slot counts once: start bit held 10 cycles, then 0x3C
    send_bit(1'b0, 10);
    chk("held_busy", busy, 1);
    for (int i = 0; i < 8; i++) send_bit(((8'h3C >> i) & 8'h01) != 0, 3);
`ifdef CLE_SDRD_PARITY_EN
    send_bit(1'b0, 3);
`endif
    send_bit(1'b1, 3);
    chk("held_data",  rx_data,  8'h3C);
    chk("held_valid", rx_valid, 1);
    chk("held_frm",   frm_err,  0);
    pop_one();

`ifdef CLE_SDRD_PARITY_EN
    // 0x03 has even ones, so parity bit 1 is wrong
    send_bit(1'b0, 3);
    for (int i = 0; i < 8; i++) send_bit(i < 2, 3);
    send_bit(1'b1, 3);
    send_bit(1'b1, 3);
    chk("par_bad_err",  par_err, 1);
    chk("par_bad_data", rx_data, 8'h03);
    chk("par_bad_vld",  rx_valid, 1);
    pop_one();
    clear_errs();
    send_bit(1'b0, 3);
    for (int i = 0; i < 8; i++) send_bit(i < 2, 3);
    send_bit(1'b0, 3);
    send_bit(1'b1, 3);
    chk("par_ok_err",  par_err, 0);
    chk("par_ok_data", rx_data, 8'h03);
    pop_one();
`else
    chk("par_tied", par_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
